// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, read-request type and lane-count helper for the 1RW+1R SRAM
package sram_pkg;

  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 4;
  localparam int SRAM_RAM_DEPTH  = 16;
  localparam int SRAM_WRITE_SIZE = 8;

  // Request address is carried zero-extended so the struct fits any ADDR_WIDTH up to 32.
  localparam int SRAM_REQ_ADDR_W = 32;

  typedef struct packed {
    logic                       en;
    logic [SRAM_REQ_ADDR_W-1:0] addr;
  } sram_rd_req_t;

  function automatic int num_wmasks(input int data_width, input int write_size);
    return data_width / write_size;
  endfunction

endpackage

// File: rtl/sram_read_port.sv
// rtl/sram_read_port.sv - read data/valid output registers with out-of-range zeroing
// Optional extra output stage when SRAM_OUTPUT_REG_EN is defined.
module sram_read_port
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int RAM_DEPTH  = SRAM_RAM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  sram_rd_req_t          req_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o
);

  localparam logic [SRAM_REQ_ADDR_W-1:0] DEPTH_L = RAM_DEPTH;

  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;

  // Idle cycles hold the previous word; out-of-range reads return zero but still count as valid.
  always_comb begin
    dout_d = dout_q;
    if (req_i.en) begin
      dout_d = (req_i.addr < DEPTH_L) ? rdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= req_i.en;
    end
  end

`ifdef SRAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q;
  logic                  valid2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout2_q  <= '0;
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid_q;
      if (valid_q) begin
        dout2_q <= dout_q;
      end
    end
  end

  assign dout_o  = dout2_q;
  assign valid_o = valid2_q;
`else
  assign dout_o  = dout_q;
  assign valid_o = valid_q;
`endif

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// rtl/sram_1rw1r_wmask.sv - 1RW (lane-masked) + 1R synchronous SRAM with collision flag
// SRAM_OUTPUT_REG_EN adds one output register stage to both read ports and the collision flag.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter  int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter  int RAM_DEPTH  = SRAM_RAM_DEPTH,
  parameter  int WRITE_SIZE = SRAM_WRITE_SIZE,
  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE)
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam logic [SRAM_REQ_ADDR_W-1:0] DEPTH_L = RAM_DEPTH;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic         addr0_in_range;
  logic         wr_en;
  logic         coll_d;
  logic         coll_q;
  sram_rd_req_t rd0_req;
  sram_rd_req_t rd1_req;

  assign addr0_in_range = SRAM_REQ_ADDR_W'(addr0) < DEPTH_L;
  assign wr_en          = !csb0 && !web0 && addr0_in_range;
  assign coll_d         = wr_en && !csb1 && (addr0 == addr1);

  always_comb begin
    rd0_req      = '0;
    rd0_req.en   = !csb0 && web0;
    rd0_req.addr = SRAM_REQ_ADDR_W'(addr0);
    rd1_req      = '0;
    rd1_req.en   = !csb1;
    rd1_req.addr = SRAM_REQ_ADDR_W'(addr1);
  end

  // Array is deliberately not reset; a request sampled while rst0 is high is dropped.
  always_ff @(posedge clk0) begin
    if (!rst0 && wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem_q[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

`ifdef SRAM_OUTPUT_REG_EN
  logic coll2_q;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      coll2_q <= 1'b0;
    end else begin
      coll2_q <= coll_q;
    end
  end

  assign collision = coll2_q;
`else
  assign collision = coll_q;
`endif

  // Both ports sample the array before this edge's write lands, giving read-before-write.
  sram_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_rd0 (
    .clk_i  (clk0),
    .rst_i  (rst0),
    .req_i  (rd0_req),
    .rdata_i(mem_q[addr0]),
    .dout_o (dout0),
    .valid_o(dout0_valid)
  );

  sram_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_rd1 (
    .clk_i  (clk0),
    .rst_i  (rst0),
    .req_i  (rd1_req),
    .rdata_i(mem_q[addr1]),
    .dout_o (dout1),
    .valid_o(dout1_valid)
  );

endmodule

// File: doc/sram_1rw1r_wmask.md
Name: sram_1rw1r_wmask

Overview:
- Parametrised successor to the team's single-port 1RW OpenRAM behavioural SRAM model.
- Provides one read/write port (port 0) with a per-lane write mask, plus one independent read-only port (port 1).
- Adds valid strobes, defined collision behaviour and out-of-range protection.
- Fully synthesizable and cycle-accurate; used by the DNN accelerator layers as the weight/bias and activation buffer model.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 4: address width in bits.
- RAM_DEPTH, 16: number of words; must be ≤ 2^ADDR_WIDTH.
- WRITE_SIZE, 8: bits per write-mask lane; DATA_WIDTH must be divisible by WRITE_SIZE.
- NUM_WMASKS, DATA_WIDTH/WRITE_SIZE: derived value, not overridable.

Ports:
- clk0, in, 1: single clock for both ports; all state changes on its rising edge.
- rst0, in, 1: reset, asynchronous, active-high.
- csb0, in, 1: port 0 chip select, active low.
- web0, in, 1: port 0 write enable, active low (0 = write, 1 = read).
- wmask0, in, NUM_WMASKS: port 0 lane enables, active high.
- addr0, in, ADDR_WIDTH: port 0 address.
- din0, in, DATA_WIDTH: port 0 write data.
- dout0, out, DATA_WIDTH: port 0 read data.
- dout0_valid, out, 1: one-cycle pulse marking new data on dout0.
- csb1, in, 1: port 1 chip select, active low.
- addr1, in, ADDR_WIDTH: port 1 address.
- dout1, out, DATA_WIDTH: port 1 read data.
- dout1_valid, out, 1: one-cycle pulse marking new data on dout1.
- collision, out, 1: pulse when port 0 writes and port 1 reads the same address at the same edge.

Behaviour:
- Reset values: dout0, dout1 = 0; dout0_valid, dout1_valid, collision = 0; all pipeline registers cleared.
- Memory array is not cleared by reset; contents survive reset.
- rst0 asserted at a sampling edge discards any request presented at that edge; memory is not modified.
- Sampling: requests are sampled at rising edge N.
- Write (csb0=0, web0=0):
  - At edge N, for each lane i with wmask0[i]=1, mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] is updated from din0.
  - Lanes with wmask0[i]=0 are unchanged.
  - wmask0 = 0 is a legal no-op.
  - The written word is visible to reads sampled at N+1 or later.
- Read latency is 1:
  - At edge N, dout registers mem[addr], using the pre-write contents of edge N.
  - dout_valid is high for the cycle following edge N.
- dout0 and dout1 hold their last value when idle or when port 0 writes; no X-driving.
- Port 0 writing: dout0_valid = 0 and dout0 is unchanged (no write-through).
- Collision: port 0 write and port 1 read to the same in-range address at edge N:
  - Port 1 returns the old data (read-before-write).
  - The write commits.
  - collision pulses high for one cycle after edge N.
- Out of range (addr ≥ RAM_DEPTH):
  - A write is ignored.
  - A read returns 0 with valid still asserted.
  - collision is never flagged.
- Back-to-back requests every cycle are supported on both ports with no bubbles.

Optional Feature:
- Macro: SRAM_OUTPUT_REG_EN.
- Defined: each read port adds one output pipeline register.
  - Read latency becomes 2; dout, valid and collision all shift one cycle later.
  - Both stages are reset to 0.
- Undefined: read latency is 1, exactly as specified above.

Decomposition:
- Package sram_pkg:
  - Localparam helper function computing NUM_WMASKS.
  - Default-width constants.
  - Typedef for the read-request struct {en, addr}.
- Sub-module sram_read_port:
  - Owns the output data/valid register(s), including the SRAM_OUTPUT_REG_EN stage.
  - Implements the out-of-range zeroing.
  - Instantiated once per port.
- The top level owns the memory array, write-mask logic and collision detect.

Test Plan:
1. Reset then idle: rst0=1 for 2 cycles, release → dout0 = dout1 = 0, all valids and collision = 0.
2. Masked write: write addr0=3, din0=16'hABCD, wmask0=2'b11; then write addr0=3, din0=16'h1234, wmask0=2'b01; port 1 reads addr 3 → dout1=16'hAB34 with dout1_valid one cycle after the read edge.
3. Collision: mem[5]=16'h0F0F; same edge port 0 writes 16'hBEEF to addr 5 and port 1 reads addr 5 → dout1=16'h0F0F, collision=1 for one cycle; next port 1 read of addr 5 → 16'hBEEF.
4. Out of range: RAM_DEPTH=12; write addr 13, then read addr 13 → dout0=0 with valid=1; mem[0..11] unchanged.
5. Streaming: port 1 reads addrs 0..15 on consecutive cycles → dout1_valid high 16 consecutive cycles, data in order. With SRAM_OUTPUT_REG_EN → same data shifted by one extra cycle.
6. Mid-operation reset: pulse rst0 asynchronously between edges while a write to addr 2 is presented → outputs go to 0 immediately; a write sampled while rst0=1 does not modify mem[2]; prior contents readable after release.
